// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: pushbutton-driven tick scheduler.
// A debounced button gives short presses (toggle RUN/PAUSE) and long presses
// (cycle the speed index). In RUN a programmable divider emits a one-cycle
// tick that advances a 5-bit LED counter.
module tick_sched_ctrl #(
    parameter int DIV_MAX     = 6000000,
    parameter int DEB_CYCLES  = 120000,
    parameter int LONG_CYCLES = 6000000
) (
    input  logic       CLK,
    input  logic       BTN_N,
    input  logic       BTN1,
    output logic [4:0] count,
    output logic       tick,
    output logic       running,
    output logic [1:0] speed
);

    localparam int DIV_W  = $clog2(DIV_MAX + 1);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_e;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              deb_q, deb_d;
    logic [DEB_W-1:0]  stab_q, stab_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              short_ev_q, short_ev_d;
    logic              long_ev_q, long_ev_d;
    state_e            state_q, state_d;
    logic [1:0]        speed_q, speed_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        count_q, count_d;
    logic [DIV_W-1:0]  limit;
    logic              tick_c;

    // Each speed step halves the divider terminal count.
    assign limit = DIV_W'(DIV_MAX >> speed_q);

    // Synchronize the raw button, then accept a new level only after it has
    // disagreed with the current one for DEB_CYCLES consecutive cycles.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sync1_d = BTN1;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        stab_d  = '0;
        if (sync2_q != deb_q) begin
            if (stab_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // Measure how long the debounced button has been held and classify the
    // press; a press that already produced a long event yields no short one.
    always_comb begin
        hold_d = hold_q;
        if (!deb_q) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end
        long_ev_d  = deb_q && (hold_q == HOLD_PRE);
        short_ev_d = deb_q && !deb_d && (hold_q < HOLD_PRE);
    end

    // RUN/PAUSE next-state and speed index, driven by the registered events.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        if (short_ev_q) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
        if (long_ev_q) begin
            speed_d = speed_q + 2'd1;
        end
    end

    // Divider and LED counter: a tick in the current cycle always counts,
    // even when a press event changes state or speed on the same edge.
    always_comb begin
        tick_c  = (state_q == ST_RUN) && (div_q == limit);
        div_d   = div_q + 1'b1;
        if (long_ev_q || (state_q != ST_RUN) || tick_c) begin
            div_d = '0;
        end
        count_d = count_q + (tick_c ? 5'd1 : 5'd0);
    end

    // All state registers, with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (!BTN_N) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            stab_q     <= '0;
            hold_q     <= '0;
            short_ev_q <= 1'b0;
            long_ev_q  <= 1'b0;
            state_q    <= ST_RUN;
            speed_q    <= 2'd0;
            div_q      <= '0;
            count_q    <= 5'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            stab_q     <= stab_d;
            hold_q     <= hold_d;
            short_ev_q <= short_ev_d;
            long_ev_q  <= long_ev_d;
            state_q    <= state_d;
            speed_q    <= speed_d;
            div_q      <= div_d;
            count_q    <= count_d;
        end
    end

    assign count   = count_q;
    assign tick    = tick_c;
    assign running = (state_q == ST_RUN);
    assign speed   = speed_q;

endmodule
